// File: rtl/uart_tx_arb_pkg.sv
// Shared UART constants, arbiter state encoding and small helpers.
// Constant-only package: no latency, no backpressure.
package uart_tx_arb_pkg;

    localparam int   DATA_WIDTH    = 8;
    localparam int   CLK_PERIOD_NS = 8;
    localparam int   CLKS_PER_BIT  = 1085;
    localparam logic START_BIT     = 1'b0;
    localparam logic STOP_BIT      = 1'b1;
    localparam int   ARB_N_REQ     = 4;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_SEND    = 2'd1,
        ARB_RELEASE = 2'd2,
        ARB_GAP     = 2'd3
    } arb_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/uart_tx_arb_if.sv
// Producer-side request/ack bus plus the uart_tx control lines, shared by the arbiter.
// Wires only: no latency; producers hold i_req until o_ack (level handshake).
interface uart_tx_arb_if
    import uart_tx_arb_pkg::*;
#(
    parameter int N_REQ = ARB_N_REQ,
    parameter int DW    = DATA_WIDTH
) ();

    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]    i_req;
    logic [N_REQ*DW-1:0] i_req_byte;
    logic [N_REQ-1:0]    o_ack;
    logic [N_REQ-1:0]    o_done;
    logic                o_err;
    logic                o_busy;
    logic [ID_W-1:0]     o_grant_id;
    logic                o_tx;
    logic [DW-1:0]       o_tx_byte;
    logic                i_tx_d;

    modport master (
        output i_req, i_req_byte, i_tx_d,
        input  o_ack, o_done, o_err, o_busy, o_grant_id, o_tx, o_tx_byte
    );

    modport slave (
        input  i_req, i_req_byte, i_tx_d,
        output o_ack, o_done, o_err, o_busy, o_grant_id, o_tx, o_tx_byte
    );

endinterface

// File: rtl/uart_tx_arb_rr_pick.sv
// Rotate-priority encoder: first set req bit at or above ptr, wrapping modulo N_REQ.
// Purely combinational, zero latency; no backpressure.
module rr_pick
    import uart_tx_arb_pkg::*;
#(
    parameter int N_REQ = ARB_N_REQ,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic             valid,
    output logic [ID_W-1:0]  index
);

    // Walk from the farthest offset down so the nearest set bit is written last and wins.
    always_comb begin
        valid = 1'b0;
        index = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % N_REQ]) begin
                valid = 1'b1;
                index = ID_W'((int'(ptr) + i) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin scheduler sharing one uart_tx among N_REQ producers, with idle gap and timeout abort.
// Latency: 1 cycle i_req->o_tx/o_ack and i_tx_d->o_done; requests ignored until the gap expires.
module uart_tx_arb
    import uart_tx_arb_pkg::*;
#(
    parameter int N_REQ          = ARB_N_REQ,
    parameter int GAP_CYCLES     = CLKS_PER_BIT,
    parameter int TIMEOUT_CYCLES = 2 * (DATA_WIDTH + 2) * CLKS_PER_BIT
) (
    input  logic          sysclk,
    input  logic          rst_n,
    uart_tx_arb_if.slave  bus
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int DW    = DATA_WIDTH;
    localparam int CNT_W = $clog2(max_int(TIMEOUT_CYCLES, GAP_CYCLES) + 1);

    arb_state_t       state;
    logic [ID_W-1:0]  prio_ptr;
    logic [CNT_W-1:0] cnt;
    logic             pick_vld;
    logic [ID_W-1:0]  pick_idx;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req   (bus.i_req),
        .ptr   (prio_ptr),
        .valid (pick_vld),
        .index (pick_idx)
    );

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ARB_IDLE;
            prio_ptr       <= '0;
            cnt            <= '0;
            bus.o_tx       <= 1'b0;
            bus.o_tx_byte  <= '0;
            bus.o_ack      <= '0;
            bus.o_done     <= '0;
            bus.o_err      <= 1'b0;
            bus.o_busy     <= 1'b0;
            bus.o_grant_id <= '0;
        end else begin
            bus.o_ack  <= '0;
            bus.o_done <= '0;
            bus.o_err  <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (pick_vld) begin
                        bus.o_tx_byte       <= bus.i_req_byte[pick_idx*DW +: DW];
                        bus.o_grant_id      <= pick_idx;
                        bus.o_ack[pick_idx] <= 1'b1;
                        bus.o_tx            <= 1'b1;
                        bus.o_busy          <= 1'b1;
                        cnt                 <= '0;
                        prio_ptr            <= (pick_idx == ID_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
                        state               <= ARB_SEND;
                    end
                end
                ARB_SEND: begin
                    // Completion takes precedence over a timeout landing on the same edge.
                    if (bus.i_tx_d) begin
                        bus.o_done[bus.o_grant_id] <= 1'b1;
                        bus.o_tx                   <= 1'b0;
                        state                      <= ARB_RELEASE;
                    end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        bus.o_err <= 1'b1;
                        bus.o_tx  <= 1'b0;
                        state     <= ARB_RELEASE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ARB_RELEASE: begin
                    if (!bus.i_tx_d) begin
                        if (GAP_CYCLES == 0) begin
                            bus.o_busy <= 1'b0;
                            state      <= ARB_IDLE;
                        end else begin
                            cnt   <= CNT_W'(GAP_CYCLES);
                            state <= ARB_GAP;
                        end
                    end
                end
                ARB_GAP: begin
                    if (cnt <= CNT_W'(1)) begin
                        bus.o_busy <= 1'b0;
                        state      <= ARB_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    bus.o_busy <= 1'b0;
                    bus.o_tx   <= 1'b0;
                    state      <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule
